// File: rtl/b03_pkg.sv
// Shared types and grant-code helpers for the b03 requester side.
package b03_pkg;

  localparam int unsigned NUM_CLIENTS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } client_state_e;

  // One-hot grant codes as driven by the arbiter (client1 is the MSB).
  localparam logic [3:0] GNT_U1 = 4'b1000;
  localparam logic [3:0] GNT_U2 = 4'b0100;
  localparam logic [3:0] GNT_U3 = 4'b0010;
  localparam logic [3:0] GNT_U4 = 4'b0001;

  // A grant bus value is legal when it is idle or exactly one client code.
  function automatic logic gnt_legal(input logic [3:0] gnt);
    return (gnt == 4'b0000) || (gnt == GNT_U1) || (gnt == GNT_U2) ||
           (gnt == GNT_U3) || (gnt == GNT_U4);
  endfunction

  // Grant bit position for a zero-based client index (client1 -> bit 3).
  function automatic logic [1:0] client_gnt_bit(input int idx);
    return 2'(3 - idx);
  endfunction

endpackage

// File: rtl/b03_client.sv
// One requester: pending-job counter plus IDLE/REQ/HOLD request FSM.
module b03_client
  import b03_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned GNT_MIN_WAIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic job,
  input  logic gnt,
  output logic request,
  output logic busy,
  output logic done,
  output logic job_drop,
  output logic starve
);

  localparam int unsigned DWELL_W = $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W  = 4;

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(TIMEOUT);
  localparam logic [DWELL_W-1:0] MIN_WAIT  = DWELL_W'(GNT_MIN_WAIT);
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  client_state_e      state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               hold_end;
  logic               starve_set;
  logic               drop_d;

  // Next-state, counter and pulse decode; grant only counts once dwell has matured.
  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    hold_d     = hold_q;
    pend_d     = pend_q;
    hold_end   = 1'b0;
    starve_set = 1'b0;
    drop_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = REQ;
          dwell_d = '0;
        end
      end
      REQ: begin
        if (dwell_q != DWELL_SAT) begin
          dwell_d = dwell_q + DWELL_W'(1);
        end else begin
          starve_set = 1'b1;
        end
        if (gnt && (dwell_q >= MIN_WAIT)) begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          hold_end = 1'b1;
          state_d  = IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Simultaneous arrival and completion cancel out.
    unique case ({job, hold_end})
      2'b10: begin
        if (pend_q == CNT_MAX) begin
          drop_d = 1'b1;
        end else begin
          pend_d = pend_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (pend_q != '0) begin
          pend_d = pend_q - CNT_W'(1);
        end
      end
      default: pend_d = pend_q;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      hold_q   <= '0;
      pend_q   <= '0;
      request  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      job_drop <= 1'b0;
      starve   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      request  <= (state_d == REQ);
      busy     <= (state_d == HOLD);
      done     <= hold_end;
      job_drop <= drop_d;
      starve   <= starve | starve_set;
    end
  end

endmodule

// File: rtl/b03_requester.sv
// Four-client requester model facing the b03 round-robin arbiter.
module b03_requester
  import b03_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned GNT_MIN_WAIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] job_in,
  input  logic [3:0] GRANT_O,
  output logic       REQUEST1,
  output logic       REQUEST2,
  output logic       REQUEST3,
  output logic       REQUEST4,
  output logic [3:0] busy,
  output logic [3:0] done,
  output logic [3:0] job_drop,
  output logic [3:0] starve,
  output logic       proto_err
);

  logic                   gnt_legal_c;
  logic [NUM_CLIENTS-1:0] req_vec;

  assign gnt_legal_c = gnt_legal(GRANT_O);

  // Illegal grant codes are masked here so no client can accept them.
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    b03_client #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W),
      .GNT_MIN_WAIT(GNT_MIN_WAIT),
      .TIMEOUT     (TIMEOUT)
    ) u_client (
      .clk     (clk),
      .rst     (rst),
      .job     (job_in[i]),
      .gnt     (gnt_legal_c & GRANT_O[client_gnt_bit(i)]),
      .request (req_vec[i]),
      .busy    (busy[i]),
      .done    (done[i]),
      .job_drop(job_drop[i]),
      .starve  (starve[i])
    );
  end

  assign REQUEST1 = req_vec[0];
  assign REQUEST2 = req_vec[1];
  assign REQUEST3 = req_vec[2];
  assign REQUEST4 = req_vec[3];

  // Sticky protocol-error flag for any grant code outside the legal set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (!gnt_legal_c) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_b03_requester.sv
// Scoreboard bench: a job-level client model predicts every cycle's outputs.
module tb_b03_requester;

  localparam int HOLD   = 4;
  localparam int CNTMAX = 7;
  localparam int MINW   = 4;
  localparam int TO     = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] job_in;
  logic [3:0] GRANT_O;
  logic       REQUEST1, REQUEST2, REQUEST3, REQUEST4;
  logic [3:0] busy, done, job_drop, starve;
  logic       proto_err;

  b03_requester dut (
    .clk      (clk),
    .rst      (rst),
    .job_in   (job_in),
    .GRANT_O  (GRANT_O),
    .REQUEST1 (REQUEST1),
    .REQUEST2 (REQUEST2),
    .REQUEST3 (REQUEST3),
    .REQUEST4 (REQUEST4),
    .busy     (busy),
    .done     (done),
    .job_drop (job_drop),
    .starve   (starve),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] drop;
    logic [3:0] starve;
    logic       perr;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: mode 0 = waiting for work, 1 = asking, 2 = using the resource.
  int m_mode[4];
  int m_wait[4];
  int m_left[4];
  int m_jobs[4];
  bit m_starve[4];
  bit m_perr;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0; m_wait[i] = 0; m_left[i] = 0; m_jobs[i] = 0; m_starve[i] = 0;
    end
    m_perr = 0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic model_step();
    obs_t e;
    bit   legal;
    bit   granted;
    bit   fin;
    legal = (GRANT_O inside {4'h0, 4'h8, 4'h4, 4'h2, 4'h1});
    e = '0;
    for (int i = 0; i < 4; i++) begin
      granted = legal && (GRANT_O == (4'h8 >> i));
      fin = 0;
      case (m_mode[i])
        2: begin
          if (m_left[i] == 1) begin
            m_mode[i] = 0;
            fin = 1;
            e.done[i] = 1'b1;
          end else begin
            m_left[i] = m_left[i] - 1;
          end
        end
        1: begin
          if (m_wait[i] == TO) m_starve[i] = 1;
          if (granted && m_wait[i] >= MINW) begin
            m_mode[i] = 2;
            m_left[i] = HOLD;
          end
          if (m_wait[i] < TO) m_wait[i] = m_wait[i] + 1;
        end
        default: begin
          if (m_jobs[i] > 0) begin
            m_mode[i] = 1;
            m_wait[i] = 0;
          end
        end
      endcase
      if (job_in[i] && !fin) begin
        if (m_jobs[i] == CNTMAX) e.drop[i] = 1'b1;
        else m_jobs[i] = m_jobs[i] + 1;
      end else if (!job_in[i] && fin && m_jobs[i] > 0) begin
        m_jobs[i] = m_jobs[i] - 1;
      end
      e.req[i]    = (m_mode[i] == 1);
      e.busy[i]   = (m_mode[i] == 2);
      e.starve[i] = m_starve[i];
    end
    if (!legal) m_perr = 1;
    e.perr = m_perr;
    exp_q.push_back(e);
  endtask

  // Reference model: advances on each clock edge, clears on reset.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst === 1'b1) model_clear();
      else model_step();
    end
  end

  // Monitor: compares each cycle's outputs against the oldest prediction.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.req    = {REQUEST4, REQUEST3, REQUEST2, REQUEST1};
        a.busy   = busy;
        a.done   = done;
        a.drop   = job_drop;
        a.starve = starve;
        a.perr   = proto_err;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t actual req=%b busy=%b done=%b drop=%b starve=%b perr=%b required req=%b busy=%b done=%b drop=%b starve=%b perr=%b",
                   $time, a.req, a.busy, a.done, a.drop, a.starve, a.perr,
                   e.req, e.busy, e.done, e.drop, e.starve, e.perr);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] j, input logic [3:0] g);
    @(negedge clk);
    job_in  = j;
    GRANT_O = g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    job_in  = '0;
    GRANT_O = '0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] rg;
  bit         seen;

  initial begin
    rst     = 1'b1;
    job_in  = '0;
    GRANT_O = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) drive(4'h0, 4'h0);

    // Client1: one job, grant offered only after it has matured in REQ.
    drive(4'b0001, 4'h0);
    repeat (6) drive(4'h0, 4'h0);
    repeat (3) drive(4'h0, 4'b1000);
    repeat (8) drive(4'h0, 4'h0);

    // Client2: grant already present before the request; must wait out dwell.
    drive(4'h0, 4'b0100);
    drive(4'b0010, 4'b0100);
    repeat (10) drive(4'h0, 4'b0100);
    repeat (4) drive(4'h0, 4'h0);

    // Client2 again, reset asserted while it holds the resource.
    drive(4'b0010, 4'h0);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      drive(4'h0, 4'b0100);
      if (busy[1] === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL hold_wait actual busy2=%b required 1 within 40 cycles", busy[1]);
    end
    drive(4'h0, 4'b0100);
    do_reset();
    repeat (3) drive(4'h0, 4'h0);

    // Client3: eight jobs without grant; the eighth is dropped.
    repeat (8) drive(4'b0100, 4'h0);
    repeat (3) drive(4'h0, 4'h0);
    do_reset();

    // Client4: starves, then a late grant; starve stays set.
    drive(4'b1000, 4'h0);
    repeat (20) drive(4'h0, 4'h0);
    repeat (3) drive(4'h0, 4'b0001);
    repeat (8) drive(4'h0, 4'h0);

    // Illegal two-hot grant while clients 1 and 2 are mature in REQ.
    drive(4'b0011, 4'h0);
    repeat (7) drive(4'h0, 4'h0);
    drive(4'h0, 4'b1100);
    repeat (4) drive(4'h0, 4'h0);
    do_reset();

    // Randomized traffic with occasional illegal grant codes.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 150; c++) begin
        logic [3:0] j;
        int         p;
        for (int b = 0; b < 4; b++) j[b] = ($urandom_range(0, 5) == 0);
        p = $urandom_range(0, 19);
        if (p < 8) rg = 4'h0;
        else if (p < 19) rg = 4'(4'h8 >> $urandom_range(0, 3));
        else rg = 4'($urandom_range(0, 15));
        drive(j, rg);
      end
      do_reset();
    end

    repeat (3) drive(4'h0, 4'h0);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
